// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, latency and output rounding/saturation helpers for fir_stream
package fir_pkg;
  localparam int MAX_W = 128;
  typedef struct packed {
    logic signed [MAX_W-1:0] val;
    logic sat;
  } sat_t;
  function automatic int acc_w(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction
  function automatic int fir_latency(int taps);
    return $clog2(taps) + 2;
  endfunction
  function automatic sat_t sat_round(logic signed [MAX_W-1:0] acc, int frac_w, int out_w);
    logic signed [MAX_W-1:0] r, hi, lo;
    sat_t s;
    r = acc;
    if (frac_w > 0) r = (acc + (MAX_W'(1) <<< (frac_w - 1))) >>> frac_w;
    hi = (MAX_W'(1) <<< (out_w - 1)) - MAX_W'(1);
    lo = -hi - MAX_W'(1);
    s.sat = (r > hi) || (r < lo);
    s.val = (r > hi) ? hi : (r < lo) ? lo : r;
    return s;
  endfunction
endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: pipelined binary adder tree, one registered level per stage, valid carried alongside
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 32,
  localparam int T = $clog2(N),
  localparam int OW = W + T
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [W-1:0]  in_data [N],
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  output logic                 busy
);
  logic signed [OW-1:0] nd [N-1];
  logic [T-1:0] vld;
  for (genvar i = 0; i < N - 1; i++) begin : g_node
    logic signed [OW-1:0] l_in, r_in;
    if (2 * i + 1 >= N - 1) begin : g_leaf
      assign l_in = OW'(in_data[2 * i + 1 - (N - 1)]);
      assign r_in = OW'(in_data[2 * i + 2 - (N - 1)]);
    end else begin : g_inner
      assign l_in = nd[2 * i + 1];
      assign r_in = nd[2 * i + 2];
    end
    // node register: sum of its two children, advancing only while the pipeline moves
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) nd[i] <= '0;
      else if (en) nd[i] <= l_in + r_in;
  end
  // valid bits shift one level per stage; flush drops everything in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld <= '0;
    else if (clr) vld <= '0;
    else if (en) vld <= (vld << 1) | T'(in_valid);
  assign out_valid = vld[T-1];
  assign out_data  = nd[0];
  assign busy      = |vld;
endmodule

// File: rtl/fir_stream.sv
// fir_stream: streaming FIR with coefficient RAM, pipelined adder tree and rounded/saturated output
module fir_stream
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     busy
);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
  logic signed [DATA_W-1:0] d [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [PW-1:0]     p [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  rnd_data;
  logic v0, v1, tree_v, tree_busy, rdy_en, stall, accept, wr_ok, rnd_sat;
  assign stall    = out_valid && !out_ready;
  assign in_ready = rdy_en && !stall && !flush && !coef_wr_en;
  assign accept   = in_valid && in_ready;
  assign busy     = v0 || v1 || tree_busy || out_valid;
  assign wr_ok    = !busy && !flush;
  assign {rnd_data, rnd_sat} = (OUT_W + 1)'(sat_round(MAX_W'(acc), FRAC_W, OUT_W));
  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_en <= 1'b0;
    else rdy_en <= 1'b1;
  // coefficient RAM: writes only land while the pipeline is empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) c[i] <= '0;
      coef_err <= 1'b0;
    end else begin
      if (coef_wr_en && wr_ok) c[coef_addr] <= coef_data;
      coef_err <= coef_wr_en && !wr_ok;
    end
  // stage 0: delay line shifts on accept and persists across idle gaps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v0 <= 1'b0;
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else if (accept) begin
      v0 <= 1'b1;
      d[0] <= in_data;
      for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
    end else if (!stall) v0 <= 1'b0;
  // stage 1: full-width tap products
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < TAPS; i++) p[i] <= '0;
    end else begin
      v1 <= flush ? 1'b0 : stall ? v1 : v0;
      if (!stall) for (int i = 0; i < TAPS; i++) p[i] <= PW'(d[i]) * PW'(c[i]);
    end
  fir_adder_tree #(.N(TAPS), .W(PW)) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!stall),
    .clr      (flush),
    .in_valid (v1),
    .in_data  (p),
    .out_valid(tree_v),
    .out_data (acc),
    .busy     (tree_busy)
  );
  // output register: rounded/saturated sample, frozen while downstream stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= flush ? 1'b0 : stall ? out_valid : tree_v;
      if (!stall) begin
        out_data <= rnd_data;
        out_sat  <= rnd_sat;
      end
    end
endmodule

// File: doc/fir_stream.md
Name: fir_stream

Overview:
Parametrised streaming FIR filter: the successor to the fixed 16-tap, 16-bit FIR used in the quantisation path.
- Generic tap count and data, coefficient and output widths.
- Addressable coefficient RAM.
- Valid/ready handshakes on input and output, with full backpressure.
- Pipelined adder tree, plus fixed-point rounding and saturation on the output.
- Sits between the sample source and the quantiser. Accepts one sample per cycle and emits one filtered sample per accepted input.

Parameters:
DATA_W, 16, signed input sample width
COEF_W, 16, signed coefficient width
TAPS, 16, number of taps (power of two, >=2)
OUT_W, 16, signed output width
FRAC_W, 0, right shift applied to the accumulator before saturation (0..ACC_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
coef_wr_en  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  tap index to write
coef_data  in  COEF_W  signed coefficient value
coef_err  out  1  one-cycle pulse: write rejected because the block was busy
flush  in  1  clears the delay line and drops all in-flight samples
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out_data  out  OUT_W  signed filtered sample
out_sat  out  1  out_data was clipped; qualified by out_valid
busy  out  1  any pipeline stage holds a valid sample

Behaviour:
- Reset (asynchronous on rst_n low): delay line, coefficients, pipeline registers and valid bits go to 0. All outputs are 0, including in_ready, until the first edge after release. Reset mid-stream discards all data.
- Stall is defined as out_valid && !out_ready. While stalled, every pipeline register and valid bit holds.
- in_ready = !stall && !flush && !coef_wr_en.
- An input accept occurs when in_valid && in_ready at a rising edge.
- Stage 0, on accept: the delay line shifts (d[0]<=in_data, d[i]<=d[i-1]) and v0 is set; v0 clears otherwise when not stalled.
- Stage 1: p[i] = d[i]*c[i], registered at full width DATA_W+COEF_W (signed).
- Stages 2..T+1, with T=$clog2(TAPS): binary adder tree, one registered level per stage.
  - Accumulator width ACC_W = DATA_W+COEF_W+T. No overflow is possible.
- Stage T+2 (output register):
  - If FRAC_W>0, add 2^(FRAC_W-1) (round half up), then arithmetic shift right by FRAC_W.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 if clipped.
- Latency: with out_ready held at 1, a sample accepted at edge k appears with out_valid=1 after edge k+T+2 (6 cycles for TAPS=16). Throughput is 1 sample per cycle.
- Output handshake: out_data, out_sat and out_valid stay stable while stalled. Samples are never dropped or reordered.
- Coefficient write:
  - Accepted only when busy=0 and flush=0: c[coef_addr]<=coef_data at the edge.
  - Otherwise the write is ignored and coef_err pulses for 1 cycle.
  - Writes and input accepts never share a cycle (in_ready is low during coef_wr_en).
- flush: at the edge, zeroes the delay line and clears all valid bits, including out_valid, regardless of stall. Coefficients are retained. flush combined with coef_wr_en: flush wins and coef_err pulses.
- Delay-line contents persist across idle gaps. Filtering is continuous until flush or reset.

Decomposition:
- Shared package fir_pkg:
  - ACC_W computation function.
  - Signed saturate-and-round function.
  - Latency constant function fir_latency(TAPS).
- Sub-module fir_adder_tree, parametrised by N inputs and width. Contains the registered levels, with a shared enable driven by !stall, and passes the valid bit alongside the data.

Test Plan:
- Moving sum: write all 16 coefficients = 1, then stream 1..16 with out_ready=1. The 16th output is 136 and arrives 6 cycles after the 16th accept. The outputs in order are 1, 3, 6, ..., 136.
- Impulse: write c[i]=i+1, then stream one sample of 1 followed by 15 zeros. The outputs are 1, 2, ..., 16, with out_sat=0 throughout.
- Saturation: all c = 0x7FFF, input stream of 0x7FFF. Once the pipeline fills, out_data=32767 with out_sat=1. With input 0x8000 and c = 0x7FFF, out_data=-32768 with out_sat=1.
- Backpressure: stream 20 samples and hold out_ready=0 for 5 cycles mid-stream. in_ready drops the same cycle, outputs are held stable, and no samples are lost or duplicated against a reference model.
- Rounding with FRAC_W=4, coefficients all 1, accumulated sum 24: out_data=2. With sum 23: out_data=1.
- Control corners:
  - coef_wr_en while busy=1: the coefficient is unchanged and coef_err=1 for 1 cycle.
  - flush mid-stream: out_valid=0 next cycle, and the next impulse yields a clean response.
  - rst_n low mid-stream: all outputs 0 immediately, without waiting for a clock edge.
